// File: rtl/if_stage.sv
// Instruction-fetch stage: one-outstanding-request fetch FSM, a one-entry skid
// buffer for responses that land during a stall, and the IF/ID pipeline register.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_write,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instrD,
    output logic [31:0] pcD,
    output logic [31:0] pc4D,
    output logic        validD,
    output logic [1:0]  dbg_state
);

    // Handshake: a request is accepted on a rising edge where imem_req && imem_ready;
    // its single response is the next cycle with imem_rvalid=1 (never the same cycle).
    typedef enum logic [1:0] {REQ = 2'd0, WAIT = 2'd1, KILL = 2'd2, HOLD = 2'd3} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcd_q, pcd_d;
    logic        valid_q, valid_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        pcd_d        = pcd_q;
        valid_d      = valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;

        unique case (state_q)
            REQ: begin
                // An accepted request is outstanding even when redirected, so drain it in KILL.
                if (branch_taken) begin
                    state_d = imem_ready ? KILL : REQ;
                end else if (imem_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (branch_taken) begin
                    state_d = imem_rvalid ? REQ : KILL;
                end else if (imem_rvalid) begin
                    if (pc_write) begin
                        instr_d = imem_rdata;
                        pcd_d   = pc_q;
                        valid_d = 1'b1;
                        pc_d    = pc_q + 32'd4;
                        state_d = REQ;
                    end else begin
                        skid_instr_d = imem_rdata;
                        skid_pc_d    = pc_q;
                        state_d      = HOLD;
                    end
                end
            end
            KILL: begin
                if (imem_rvalid) begin
                    state_d = REQ;
                end
            end
            HOLD: begin
                if (branch_taken) begin
                    state_d = REQ;
                end else if (pc_write) begin
                    instr_d = skid_instr_q;
                    pcd_d   = skid_pc_q;
                    valid_d = 1'b1;
                    pc_d    = skid_pc_q + 32'd4;
                    state_d = REQ;
                end
            end
            default: state_d = REQ;
        endcase

        // Redirect overrides stalls and any same-cycle response; pcD keeps its last value.
        if (branch_taken) begin
            pc_d    = {branch_target[31:2], 2'b00};
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= REQ;
            pc_q         <= RESET_PC;
            instr_q      <= NOP_INSTR;
            pcd_q        <= 32'd0;
            valid_q      <= 1'b0;
            skid_instr_q <= 32'd0;
            skid_pc_q    <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            pcd_q        <= pcd_d;
            valid_q      <= valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    assign imem_req  = (state_q == REQ) && !rst;
    assign imem_addr = pc_q;
    assign instrD    = instr_q;
    assign pcD       = pcd_q;
    assign pc4D      = pcd_q + 32'd4;
    assign validD    = valid_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a small memory model, an expected-instruction queue
// filled by the stimulus, and a negedge monitor that pops and compares each new IF/ID entry.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [1:0] ST_REQ = 2'd0, ST_KILL = 2'd2, ST_HOLD = 2'd3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pc_write = 1'b1;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'hDEAD_BEEF;
    logic [31:0] instrD, pcD, pc4D;
    logic        validD;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    int mem_lat = 1;
    logic [63:0] exp_q[$];

    if_stage dut (
        .clk(clk), .rst(rst), .pc_write(pc_write), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instrD(instrD), .pcD(pcD), .pc4D(pc4D), .validD(validD), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // ---------------- memory model ----------------
    initial begin
        logic        acc_seen;
        logic [31:0] acc_addr;
        logic [31:0] pend_addr;
        int          cnt;
        cnt = 0;
        pend_addr = 32'd0;
        forever begin
            @(negedge clk);
            acc_seen = imem_req && imem_ready;
            acc_addr = imem_addr;
            @(posedge clk);
            #1;
            imem_rvalid = 1'b0;
            imem_rdata  = 32'hDEAD_BEEF;
            if (acc_seen) begin
                checks++;
                if (cnt != 0) begin
                    errors++;
                    $display("FAIL outstanding: new request at %h accepted with %0d cycles left, required none pending", acc_addr, cnt);
                end
                pend_addr = acc_addr;
                cnt = mem_lat;
            end
            if (cnt != 0) begin
                cnt--;
                if (cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_data(pend_addr);
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic        prev_valid;
        logic [31:0] prev_pc, prev_instr;
        logic [63:0] e;
        prev_valid = 1'b0;
        prev_pc = 32'd0;
        prev_instr = 32'd0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                checks++;
                if (pc4D !== pcD + 32'd4) begin
                    errors++;
                    $display("FAIL pc4d: got %h, required %h", pc4D, pcD + 32'd4);
                end
                if (validD && (!prev_valid || pcD !== prev_pc || instrD !== prev_instr)) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL fetch: unexpected pc=%h instr=%h, required nothing", pcD, instrD);
                    end else begin
                        e = exp_q.pop_front();
                        if ({pcD, instrD} !== e) begin
                            errors++;
                            $display("FAIL fetch: got pc=%h instr=%h, required pc=%h instr=%h",
                                     pcD, instrD, e[63:32], e[31:0]);
                        end
                    end
                end
            end
            prev_valid = validD;
            prev_pc    = pcD;
            prev_instr = instrD;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc);
        exp_q.push_back({pc, mem_data(pc)});
    endtask

    task automatic wait_empty(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d instructions still pending after %0d cycles, required 0", name, exp_q.size(), budget);
            exp_q.delete();
        end
    endtask

    task automatic wait_req(input string name, input int budget);
        int n = 0;
        while (!imem_req && n < budget) begin
            tick();
            n++;
        end
        chk(name, {31'd0, imem_req}, 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset values
        tick();
        tick();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_state", {30'd0, dbg_state}, {30'd0, ST_REQ});
        chk("rst_instr", instrD, NOP);
        chk("rst_pcd", pcD, 32'd0);
        chk("rst_pc4d", pc4D, 32'd4);
        chk("rst_valid", {31'd0, validD}, 32'd0);

        // Streaming fetch, 1-cycle memory
        for (int i = 0; i < 8; i++) push_exp(32'(i * 4));
        imem_ready = 1'b1;
        rst = 1'b0;
        #1;
        chk("first_req", {31'd0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'h0000_0000);
        wait_empty("stream", 60);

        // Stall while the response for pc 32 lands in WAIT
        pc_write = 1'b0;
        repeat (3) tick();
        chk("hold_state", {30'd0, dbg_state}, {30'd0, ST_HOLD});
        chk("hold_instr", instrD, mem_data(32'd28));
        chk("hold_pcd", pcD, 32'd28);
        chk("hold_valid", {31'd0, validD}, 32'd1);
        push_exp(32'd32);
        push_exp(32'd36);
        pc_write = 1'b1;
        tick();
        chk("release_pcd", pcD, 32'd32);
        chk("release_instr", instrD, mem_data(32'd32));
        chk("release_addr", imem_addr, 32'd36);
        mem_lat = 3;
        wait_empty("release", 30);

        // Redirect while the request for pc 40 is outstanding
        branch_target = 32'h0000_0103;
        branch_taken = 1'b1;
        tick();
        branch_taken = 1'b0;
        chk("kill_state", {30'd0, dbg_state}, {30'd0, ST_KILL});
        chk("kill_valid", {31'd0, validD}, 32'd0);
        chk("kill_instr", instrD, NOP);
        chk("kill_pcd", pcD, 32'd36);
        chk("kill_req", {31'd0, imem_req}, 32'd0);
        push_exp(32'h0000_0100);
        push_exp(32'h0000_0104);
        wait_req("kill_wait_req", 10);
        chk("redirect_addr", imem_addr, 32'h0000_0100);
        wait_empty("redirect", 30);

        // Redirect and stall in the same cycle
        branch_target = 32'h0000_0200;
        branch_taken = 1'b1;
        pc_write = 1'b0;
        tick();
        branch_taken = 1'b0;
        chk("prio_valid", {31'd0, validD}, 32'd0);
        chk("prio_instr", instrD, NOP);
        chk("prio_pcd", pcD, 32'h0000_0104);
        chk("prio_state", {30'd0, dbg_state}, {30'd0, ST_KILL});
        pc_write = 1'b1;
        push_exp(32'h0000_0200);
        push_exp(32'h0000_0204);
        wait_empty("prio", 30);

        // PC wrap at the top of the address space
        branch_target = 32'hFFFF_FFFD;
        branch_taken = 1'b1;
        tick();
        branch_taken = 1'b0;
        push_exp(32'hFFFF_FFFC);
        push_exp(32'h0000_0000);
        push_exp(32'h0000_0004);
        begin
            int n = 0;
            while (!(validD && pcD == 32'hFFFF_FFFC) && n < 30) begin
                tick();
                n++;
            end
        end
        chk("wrap_pcd", pcD, 32'hFFFF_FFFC);
        chk("wrap_pc4d", pc4D, 32'h0000_0000);
        chk("wrap_req", {31'd0, imem_req}, 32'd1);
        chk("wrap_addr", imem_addr, 32'h0000_0000);
        wait_empty("wrap", 30);

        // Reset while in WAIT; the late response must be ignored
        rst = 1'b1;
        imem_ready = 1'b0;
        tick();
        chk("mid_rst_state", {30'd0, dbg_state}, {30'd0, ST_REQ});
        chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
        chk("mid_rst_valid", {31'd0, validD}, 32'd0);
        chk("mid_rst_instr", instrD, NOP);
        chk("mid_rst_pcd", pcD, 32'd0);
        rst = 1'b0;
        repeat (4) tick();
        chk("late_valid", {31'd0, validD}, 32'd0);
        chk("late_state", {30'd0, dbg_state}, {30'd0, ST_REQ});
        chk("late_addr", imem_addr, 32'h0000_0000);
        mem_lat = 1;
        push_exp(32'd0);
        push_exp(32'd4);
        imem_ready = 1'b1;
        wait_empty("after_rst", 30);

        // Quiesce and report
        pc_write = 1'b0;
        imem_ready = 1'b0;
        repeat (4) tick();
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
